// File: rtl/cotm32_bus_arbiter.sv
// cotm32 memory-port arbiter: one outstanding access shared by IFU and LSU,
// with memory-map decode, error responses and LSU priority bounded by an IFU fairness guard.
package cotm32_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INST_MEM_START = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_MEM_END   = 32'h0000_03FF;
  localparam logic [XLEN-1:0] ROM_MEM_START  = 32'h0001_0000;
  localparam logic [XLEN-1:0] ROM_MEM_END    = 32'h0001_0FFF;
  localparam logic [XLEN-1:0] DATA_MEM_START = 32'h1000_0000;
  localparam logic [XLEN-1:0] DATA_MEM_END   = 32'h1000_0FFF;

  typedef enum logic [1:0] {
    LSU_MEM_SRC_UNKNOWN = 2'd0,
    LSU_MEM_SRC_ROM     = 2'd1,
    LSU_MEM_SRC_DMEM    = 2'd2
  } lsu_mem_src_t;

  function automatic logic in_range(input logic [XLEN-1:0] a, input logic [XLEN-1:0] lo,
                                    input logic [XLEN-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction
endpackage

module cotm32_bus_arbiter
  import cotm32_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic              ls_we,
  input  logic [3:0]        ls_wstrb,
  input  logic [XLEN-1:0]   ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              ls_err,
  output logic              m_req,
  output logic [XLEN-1:0]   m_addr,
  output logic              m_we,
  output logic [3:0]        m_wstrb,
  output logic [XLEN-1:0]   m_wdata,
  output lsu_mem_src_t      m_src,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata
);

  localparam int CW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [CW-1:0] FAIR_CNT = CW'(FAIR_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ERR} state_t;

  state_t        state_r;
  logic          owner_r;
  logic [XLEN-1:0] addr_r;
  logic          we_r;
  logic [3:0]    wstrb_r;
  logic [XLEN-1:0] wdata_r;
  lsu_mem_src_t  src_r;
  logic [CW-1:0] starve_r;

  logic          grant_s;
  logic          pick_ls_s;
  logic [XLEN-1:0] req_addr_s;
  logic          req_we_s;
  logic [3:0]    req_wstrb_s;
  logic [XLEN-1:0] req_wdata_s;
  logic          in_inst_s;
  logic          in_rom_s;
  logic          in_dmem_s;
  logic          legal_s;
  lsu_mem_src_t  req_src_s;
  logic          rsp_s;
  logic          err_s;

  // Pick the winner and decode its request while idle; IFU fetches become plain word reads
  always_comb begin
    pick_ls_s   = 1'b0;
    req_addr_s  = '0;
    req_we_s    = 1'b0;
    req_wstrb_s = 4'b0000;
    req_wdata_s = '0;
    legal_s     = 1'b0;
    req_src_s   = LSU_MEM_SRC_UNKNOWN;
    if (ls_req && (!if_req || (starve_r != FAIR_CNT))) begin
      pick_ls_s = 1'b1;
    end else begin
      pick_ls_s = 1'b0;
    end
    grant_s = rst_n && (state_r == ST_IDLE) && (if_req || ls_req);
    if (pick_ls_s) begin
      req_addr_s  = ls_addr;
      req_we_s    = ls_we;
      req_wstrb_s = ls_wstrb;
      req_wdata_s = ls_wdata;
    end else begin
      req_addr_s  = if_addr;
      req_we_s    = 1'b0;
      req_wstrb_s = 4'b0000;
      req_wdata_s = '0;
    end
    in_inst_s = in_range(req_addr_s, INST_MEM_START, INST_MEM_END);
    in_rom_s  = in_range(req_addr_s, ROM_MEM_START, ROM_MEM_END);
    in_dmem_s = in_range(req_addr_s, DATA_MEM_START, DATA_MEM_END);
    if (pick_ls_s) begin
      legal_s = (in_rom_s && !req_we_s) || in_dmem_s;
    end else begin
      legal_s = in_inst_s || in_rom_s;
    end
    if (in_rom_s) begin
      req_src_s = LSU_MEM_SRC_ROM;
    end else if (in_dmem_s) begin
      req_src_s = LSU_MEM_SRC_DMEM;
    end else begin
      req_src_s = LSU_MEM_SRC_UNKNOWN;
    end
  end

  assign rsp_s     = (state_r == ST_WAIT) && m_rvalid;
  assign err_s     = (state_r == ST_ERR);
  assign if_gnt    = grant_s && !pick_ls_s;
  assign ls_gnt    = grant_s && pick_ls_s;
  assign if_rvalid = (rsp_s || err_s) && !owner_r;
  assign ls_rvalid = (rsp_s || err_s) && owner_r;
  assign if_err    = err_s && !owner_r;
  assign ls_err    = err_s && owner_r;
  assign if_rdata  = (rsp_s && !owner_r) ? m_rdata : '0;
  assign ls_rdata  = (rsp_s && owner_r) ? m_rdata : '0;
  assign m_req     = (state_r == ST_ISSUE);
  assign m_addr    = addr_r;
  assign m_we      = we_r;
  assign m_wstrb   = wstrb_r;
  assign m_wdata   = wdata_r;
  assign m_src     = src_r;

  // Transaction sequencer with request latches and the IFU starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      owner_r  <= 1'b0;
      addr_r   <= '0;
      we_r     <= 1'b0;
      wstrb_r  <= 4'b0000;
      wdata_r  <= '0;
      src_r    <= LSU_MEM_SRC_UNKNOWN;
      starve_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            owner_r <= pick_ls_s;
            addr_r  <= req_addr_s;
            we_r    <= req_we_s;
            wstrb_r <= req_wstrb_s;
            wdata_r <= req_wdata_s;
            src_r   <= req_src_s;
            state_r <= legal_s ? ST_ISSUE : ST_ERR;
            // Only an LSU win over a waiting IFU counts toward starvation
            if (!pick_ls_s || !if_req) begin
              starve_r <= '0;
            end else if (starve_r != FAIR_CNT) begin
              starve_r <= starve_r + CW'(1);
            end else begin
              starve_r <= starve_r;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: state_r <= m_gnt ? ST_WAIT : ST_ISSUE;
        ST_WAIT:  state_r <= m_rvalid ? ST_IDLE : ST_WAIT;
        ST_ERR:   state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cotm32_bus_arbiter.sv
// Directed and randomized bench for cotm32_bus_arbiter against a rule-level model of
// arbitration, fairness and memory-map legality.
module tb_cotm32_bus_arbiter;
  import cotm32_pkg::*;

  localparam int FAIR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [3:0]  ls_wstrb;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;
  lsu_mem_src_t m_src;

  int total = 0;
  int fails = 0;
  int starve = 0;

  always #5 clk = ~clk;

  cotm32_bus_arbiter #(.FAIR_LIMIT(FAIR)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wstrb(ls_wstrb),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_src(m_src), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_inst(input logic [31:0] a);
    return a <= 32'h0000_03FF;
  endfunction
  function automatic logic is_rom(input logic [31:0] a);
    return (a >= 32'h0001_0000) && (a <= 32'h0001_0FFF);
  endfunction
  function automatic logic is_dmem(input logic [31:0] a);
    return (a >= 32'h1000_0000) && (a <= 32'h1000_0FFF);
  endfunction
  function automatic lsu_mem_src_t exp_src(input logic [31:0] a);
    if (is_rom(a)) return LSU_MEM_SRC_ROM;
    else if (is_dmem(a)) return LSU_MEM_SRC_DMEM;
    else return LSU_MEM_SRC_UNKNOWN;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_if_err"}, 32'(if_err), 32'd0);
    chk({tag, "_ls_gnt"}, 32'(ls_gnt), 32'd0);
    chk({tag, "_ls_rvalid"}, 32'(ls_rvalid), 32'd0);
    chk({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    chk({tag, "_ls_err"}, 32'(ls_err), 32'd0);
    chk({tag, "_m_req"}, 32'(m_req), 32'd0);
    chk({tag, "_m_addr"}, m_addr, 32'd0);
    chk({tag, "_m_we"}, 32'(m_we), 32'd0);
    chk({tag, "_m_wstrb"}, 32'(m_wstrb), 32'd0);
    chk({tag, "_m_wdata"}, m_wdata, 32'd0);
    chk({tag, "_m_src"}, 32'(m_src), 32'(LSU_MEM_SRC_UNKNOWN));
  endtask

  // One arbitration slot starting in IDLE, run to completion of the winner's access
  task automatic step(input logic ireq, input logic [31:0] iaddr, input logic lreq,
                      input logic [31:0] laddr, input logic lwe, input logic [3:0] lstrb,
                      input logic [31:0] lwd, input int gdelay, input logic [31:0] rd,
                      output logic saw_ls);
    logic        win_ls, legal;
    logic [31:0] a;
    if_req = ireq; if_addr = iaddr;
    ls_req = lreq; ls_addr = laddr; ls_we = lwe; ls_wstrb = lstrb; ls_wdata = lwd;
    @(negedge clk);
    saw_ls = ls_gnt;
    if (!ireq && !lreq) begin
      chk("nogrant_if_gnt", 32'(if_gnt), 32'd0);
      chk("nogrant_ls_gnt", 32'(ls_gnt), 32'd0);
      @(posedge clk); #1;
      return;
    end
    win_ls = lreq && (!ireq || starve < FAIR);
    a = win_ls ? laddr : iaddr;
    legal = win_ls ? ((is_rom(a) && !lwe) || is_dmem(a)) : (is_inst(a) || is_rom(a));
    if (win_ls && ireq) starve = (starve < FAIR) ? starve + 1 : FAIR;
    else starve = 0;
    chk("arb_if_gnt", 32'(if_gnt), 32'(!win_ls));
    chk("arb_ls_gnt", 32'(ls_gnt), 32'(win_ls));
    chk("arb_m_req", 32'(m_req), 32'd0);
    @(posedge clk); #1;
    if (win_ls) begin
      ls_addr = $urandom; ls_we = ~lwe; ls_wstrb = ~lstrb; ls_wdata = ~lwd;
    end else begin
      if_addr = $urandom;
    end
    if (!legal) begin
      m_rvalid = 1'b1; m_rdata = $urandom;
      @(negedge clk);
      chk("err_m_req", 32'(m_req), 32'd0);
      chk("err_if_rvalid", 32'(if_rvalid), 32'(!win_ls));
      chk("err_ls_rvalid", 32'(ls_rvalid), 32'(win_ls));
      chk("err_if_err", 32'(if_err), 32'(!win_ls));
      chk("err_ls_err", 32'(ls_err), 32'(win_ls));
      chk("err_rdata", win_ls ? ls_rdata : if_rdata, 32'd0);
      chk("err_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
      @(posedge clk); #1;
      m_rvalid = 1'b0;
    end else begin
      for (int i = 0; i <= gdelay; i++) begin
        m_gnt = (i == gdelay);
        m_rvalid = (i == 0) && (gdelay > 0);
        @(negedge clk);
        chk("iss_m_req", 32'(m_req), 32'd1);
        chk("iss_m_addr", m_addr, a);
        chk("iss_m_we", 32'(m_we), 32'(win_ls && lwe));
        chk("iss_m_wstrb", 32'(m_wstrb), win_ls ? 32'(lstrb) : 32'd0);
        chk("iss_m_wdata", m_wdata, win_ls ? lwd : 32'd0);
        chk("iss_m_src", 32'(m_src), 32'(exp_src(a)));
        chk("iss_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
        chk("iss_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
        @(posedge clk); #1;
      end
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = rd;
      @(negedge clk);
      chk("rsp_m_req", 32'(m_req), 32'd0);
      chk("rsp_if_rvalid", 32'(if_rvalid), 32'(!win_ls));
      chk("rsp_ls_rvalid", 32'(ls_rvalid), 32'(win_ls));
      chk("rsp_rdata", win_ls ? ls_rdata : if_rdata, rd);
      chk("rsp_err", 32'({if_err, ls_err}), 32'd0);
      chk("rsp_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
      @(posedge clk); #1;
      m_rvalid = 1'b0;
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    logic saw;
    logic [31:0] pool [12];
    pool = '{32'h0000_0000, 32'h0000_03FC, 32'h0000_03FF, 32'h0000_0400,
             32'h0001_0000, 32'h0001_0FFC, 32'h0001_1000, 32'h1000_0000,
             32'h1000_0FFF, 32'h1000_1000, 32'h2000_0000, 32'h0000_0040};
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_wstrb = 4'b0000; ls_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single IFU fetch
    step(1'b1, 32'h0000_0004, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0051_3023, saw);

    // contention with fairness: LS,LS,LS,LS,IF repeating
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 32'h0000_0100 + 32'(k * 4), 1'b1, 32'h1000_0020, 1'b0, 4'h0, 32'h0,
           k % 2, $urandom, saw);
      chk("contention_seq", 32'(saw), 32'((k % 5) != 4));
    end

    // illegal accesses
    step(1'b0, 32'h0, 1'b1, 32'h0001_0000, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, saw);
    step(1'b1, 32'h1000_0000, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0, saw);
    step(1'b0, 32'h0, 1'b1, 32'h2000_0000, 1'b0, 4'h0, 32'h0, 0, 32'h0, saw);

    // memory backpressure
    step(1'b0, 32'h0, 1'b1, 32'h1000_0010, 1'b1, 4'b0011, 32'h1234_5678, 3, 32'h0, saw);

    // region boundaries
    step(1'b0, 32'h0, 1'b1, 32'h1000_0FFF, 1'b0, 4'h0, 32'h0, 1, 32'hA5A5_0001, saw);
    step(1'b0, 32'h0, 1'b1, 32'h1000_1000, 1'b0, 4'h0, 32'h0, 0, 32'h0, saw);
    step(1'b1, 32'h0000_03FF, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h5A5A_0002, saw);
    step(1'b1, 32'h0000_0400, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0, saw);

    // reset while in WAIT
    if_req = 1'b1; if_addr = 32'h0000_0008;
    @(negedge clk);
    chk("rstw_if_gnt", 32'(if_gnt), 32'd1);
    starve = 0;
    @(posedge clk); #1;
    if_req = 1'b0; m_gnt = 1'b1;
    @(posedge clk); #1;
    m_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstw");
    starve = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    m_rvalid = 1'b1; m_rdata = 32'hFFFF_0000;
    @(negedge clk);
    chk("late_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("late_ls_rvalid", 32'(ls_rvalid), 32'd0);
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    step(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0BAD_F00D, saw);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      step(1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)],
           1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)],
           1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           int'($urandom_range(0, 3)), $urandom, saw);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/cotm32_bus_arbiter.md
# cotm32_bus_arbiter

Single-outstanding memory bus arbiter for the cotm32 core. It shares one memory port, which fronts instruction memory, ROM and data memory, between the instruction fetch unit (IFU) and the load-store unit (LSU). For each request it decodes the target region against the core memory map, rejects illegal accesses with an error response, and sequences the request/accept/response handshake. LSU has priority, with a bounded-starvation guard for IFU.

## Interface
Parameters:
- `FAIR_LIMIT`, default 4: consecutive LSU grants allowed while IFU is waiting before IFU is forced to win.
- Address and data widths are `XLEN`. Region bounds are the package memory-map constants `INST_MEM_*`, `ROM_MEM_*` and `DATA_MEM_*`.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: IFU word-read request.
- `if_addr` in XLEN: IFU address.
- `if_gnt` out 1: IFU request accepted (1-cycle pulse).
- `if_rvalid` out 1: IFU response (1-cycle pulse).
- `if_rdata` out XLEN: IFU read data.
- `if_err` out 1: IFU access fault, valid with `if_rvalid`.
- `ls_req` in 1: LSU request.
- `ls_addr` in XLEN: LSU address.
- `ls_we` in 1: LSU store.
- `ls_wstrb` in 4: LSU byte strobes.
- `ls_wdata` in XLEN: LSU store data.
- `ls_gnt`, `ls_rvalid`, `ls_rdata`, `ls_err`: same meaning as the IFU counterparts.
- `m_req` out 1: memory request.
- `m_addr` out XLEN: memory address.
- `m_we` out 1: memory write.
- `m_wstrb` out 4: memory byte strobes.
- `m_wdata` out XLEN: memory write data.
- `m_src` out `lsu_mem_src_t`: decoded target region.
- `m_gnt` in 1: memory accepted `m_req`.
- `m_rvalid` in 1: memory response (read data or write ack).
- `m_rdata` in XLEN: memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ERR.
- **IDLE, arbitration:**
  - Arbitration happens only in IDLE.
  - If exactly one requester has `req`=1, that requester wins.
  - If both do, LSU wins unless `starve_cnt` == `FAIR_LIMIT`, in which case IFU wins.
  - The winner's `gnt` is asserted combinationally in the same cycle. Its request fields and an owner bit are latched.
- **Starvation counter:**
  - `starve_cnt` increments on an LSU grant made while `if_req`=1, saturating at `FAIR_LIMIT`.
  - It clears on any IFU grant, and on any LSU grant made while `if_req`=0.
- **Region decode of the latched request:**
  - IFU legal regions: INST or ROM.
  - LSU legal regions: ROM with `we`=0, or DMEM.
  - Bounds are inclusive start..end.
- **Transitions:**
  - IDLE -> ISSUE if the decoded access is legal.
  - IDLE -> ERR if it is illegal. This covers an out-of-map address, IFU to DMEM, LSU to INST, and any store to ROM.
  - IFU fetches are issued as word reads: `m_we`=0, `m_wstrb`=4'b0000, `m_wdata`=0.
- **ISSUE:**
  - `m_req`=1, with the latched `m_addr`/`m_we`/`m_wstrb`/`m_wdata` and `m_src` (ROM or DMEM; INST is reported as ROM_SRC_UNKNOWN→`LSU_MEM_SRC_UNKNOWN`).
  - Held stable until `m_gnt`=1, then -> WAIT.
- **WAIT:**
  - On `m_rvalid`=1, the owner's `rvalid`=1 and `rdata`=`m_rdata` combinationally, `err`=0.
  - -> IDLE next cycle.
- **ERR:** the owner's `rvalid`=1, `err`=1, `rdata`=0 for one cycle, then -> IDLE.
- `m_rvalid` outside WAIT is ignored.
- The non-owner's `rvalid` is always 0.
- Requesters hold `req` and their fields stable until `gnt`. After `gnt` they may change fields immediately.
- Writes complete via `m_rvalid`. `ls_rdata` on a write response is don't-care, and is passed through.

## Timing
- Reset (async assert, sync release): state=IDLE, `starve_cnt`=0, latches=0. All outputs are 0 (`m_src`=`LSU_MEM_SRC_UNKNOWN`).
- Reset mid-transaction aborts it. No response is delivered.
- Best-case legal access:
  - req at cycle 0, `gnt` at cycle 0.
  - `m_req` at cycle 1. With `m_gnt` at cycle 1 -> WAIT at cycle 2.
  - `m_rvalid` at cycle 2 -> `rvalid` at cycle 2.
  - The next arbitration is at cycle 3. Throughput is 1 access per 3 cycles.
- Illegal access: `gnt` at cycle 0, ERR response at cycle 1, next arbitration at cycle 2.
- No `gnt` is ever asserted outside IDLE. At most one `gnt` is asserted per cycle.
- A `req` arriving in ISSUE/WAIT/ERR waits for IDLE.

## Test plan
- **Single IFU fetch:** `if_addr`=0x0000_0004, memory `m_gnt` same cycle, `m_rdata`=0x0051_3023 next cycle. Expect `if_gnt` at cycle 0, `m_req`/`m_addr`=0x4 at cycle 1, `if_rvalid`/`if_rdata`=0x0051_3023/`if_err`=0 at cycle 2, `m_src`=UNKNOWN.
- **Contention with fairness:** `if_req` and `ls_req` held high continuously, `FAIR_LIMIT`=4, with LSU re-requesting after each response. Expect the grant sequence LS,LS,LS,LS,IF,LS…, and `starve_cnt` returns to 0 after the IF grant.
- **Illegal accesses:**
  - LSU store to 0x0001_0000 (ROM): expect `ls_gnt`, no `m_req`, `ls_rvalid`=1 with `ls_err`=1 one cycle later.
  - IFU fetch at 0x1000_0000: expect `if_err`=1.
  - LSU load at 0x2000_0000: expect `ls_err`=1.
- **Memory backpressure:** LSU store to 0x1000_0010, `wstrb`=4'b0011, `m_gnt` low for 3 cycles. Expect `m_req` and all fields stable for 4 cycles, `m_src`=DMEM, and `ls_rvalid` on `m_rvalid`.
- **Region boundaries:**
  - LSU load at 0x1000_0FFF: legal.
  - LSU load at 0x1000_1000: error.
  - IFU fetch at 0x0000_03FF: legal.
  - IFU fetch at 0x0000_0400: error.
- **Reset in WAIT:** drop `rst_n` during WAIT. Expect all outputs 0 immediately. A late `m_rvalid` after release produces no `rvalid`. The next IFU req is granted normally.
